// File: rtl/reaction_timer_if.sv
// Bundle of the strobes, button and result signals that pass between the
// start-light side and the reaction timer.
interface reaction_timer_if #(
   parameter int NDIGITS = 4
);
   logic                   tick_ms;
   logic                   seq_start;
   logic                   lights_out;
   logic                   button;
   logic [4*NDIGITS-1:0]   bcd;
   logic                   result_valid;
   logic                   jump_start;
   logic                   no_response;
   logic                   busy;
   logic [2:0]             dbg_state;

   // Strobes are single-cycle pulses sampled on the rising sysclk edge;
   // there is no back-pressure, so the timer must act on every pulse it sees.
   modport master (
      output tick_ms, seq_start, lights_out, button,
      input  bcd, result_valid, jump_start, no_response, busy, dbg_state
   );

   modport slave (
      input  tick_ms, seq_start, lights_out, button,
      output bcd, result_valid, jump_start, no_response, busy, dbg_state
   );
endinterface

// File: rtl/reaction_timer.sv
// Measures the driver's reaction (ms, BCD) from lights-out to button press,
// flagging jump starts and no-response timeouts.
module reaction_timer #(
   parameter int NDIGITS     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sysclk,
   input  logic              rst_n,
   reaction_timer_if.slave   bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_TIMING = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_JUMP   = 3'd4;
   localparam logic [2:0] S_NORESP = 3'd5;

   localparam int W = 4*NDIGITS;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_prev;
   logic [2:0]             r_state;
   logic [W-1:0]           r_bcd;
   logic                   r_valid;
   logic                   r_jump;
   logic                   r_noresp;
   logic                   r_busy;

   logic                   w_press;
   logic                   w_all9;
   logic [W-1:0]           w_bcd_inc;

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] res;
      logic         carry;
      res   = v;
      carry = 1'b1;
      for (int d = 0; d < NDIGITS; d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               res[4*d +: 4] = 4'd0;
            end else begin
               res[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Edge detect on the last synchroniser stage so a held button yields one press.
   assign w_press   = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
   assign w_all9    = (r_bcd == {NDIGITS{4'h9}});
   assign w_bcd_inc = bcd_inc(r_bcd);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync      <= '0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.button};
         r_sync_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_bcd    <= '0;
         r_valid  <= 1'b0;
         r_jump   <= 1'b0;
         r_noresp <= 1'b0;
         r_busy   <= 1'b0;
      end else if (bus.seq_start) begin
         r_state  <= S_ARMED;
         r_bcd    <= '0;
         r_valid  <= 1'b0;
         r_jump   <= 1'b0;
         r_noresp <= 1'b0;
         r_busy   <= 1'b1;
      end else begin
         case (r_state)
            S_ARMED: begin
               if (w_press && bus.lights_out) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (w_press) begin
                  r_state <= S_JUMP;
                  r_jump  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (bus.lights_out) begin
                  r_state <= S_TIMING;
               end
            end
            S_TIMING: begin
               // A press in the same cycle as a tick wins; that tick is dropped.
               if (w_press) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (bus.tick_ms) begin
                  if (w_all9) begin
                     r_state  <= S_NORESP;
                     r_noresp <= 1'b1;
                     r_busy   <= 1'b0;
                  end else begin
                     r_bcd <= w_bcd_inc;
                  end
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign bus.bcd          = r_bcd;
   assign bus.result_valid = r_valid;
   assign bus.jump_start   = r_jump;
   assign bus.no_response  = r_noresp;
   assign bus.busy         = r_busy;
   assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: reset, timing, jump start, timeout,
// held button, press/tick collision and asynchronous reset.
module tb_reaction_timer;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   reaction_timer_if #(.NDIGITS(4)) bus ();

   reaction_timer #(.NDIGITS(4), .SYNC_STAGES(2)) dut (
      .sysclk (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [15:0] e_bcd, input logic e_valid,
                           input logic e_jump, input logic e_noresp, input logic e_busy,
                           input logic [2:0] e_state);
      chk({tag, ".bcd"},   {16'h0, bus.bcd},          {16'h0, e_bcd});
      chk({tag, ".valid"}, {31'h0, bus.result_valid}, {31'h0, e_valid});
      chk({tag, ".jump"},  {31'h0, bus.jump_start},   {31'h0, e_jump});
      chk({tag, ".nores"}, {31'h0, bus.no_response},  {31'h0, e_noresp});
      chk({tag, ".busy"},  {31'h0, bus.busy},         {31'h0, e_busy});
      chk({tag, ".state"}, {29'h0, bus.dbg_state},    {29'h0, e_state});
   endtask

   task automatic pulse_seq();
      bus.seq_start = 1'b1;
      cyc();
      bus.seq_start = 1'b0;
   endtask

   task automatic pulse_lights();
      bus.lights_out = 1'b1;
      cyc();
      bus.lights_out = 1'b0;
   endtask

   task automatic ticks(input int n);
      bus.tick_ms = 1'b1;
      repeat (n) cyc();
      bus.tick_ms = 1'b0;
   endtask

   // Press lands on the third edge after the button rises; release then flush the chain.
   task automatic press();
      bus.button = 1'b1;
      repeat (3) cyc();
      bus.button = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst_n          = 1'b0;
      bus.tick_ms    = 1'b0;
      bus.seq_start  = 1'b0;
      bus.lights_out = 1'b0;
      bus.button     = 1'b0;
      repeat (3) cyc();
      chk_outs("reset", 16'h0000, 0, 0, 0, 0, 3'd0);
      rst_n = 1'b1;
      cyc();

      // IDLE ignores lights_out and presses
      pulse_lights();
      press();
      chk_outs("idle_ignore", 16'h0000, 0, 0, 0, 0, 3'd0);

      // 1: normal measurement of 237 ms
      pulse_seq();
      chk_outs("t1_armed", 16'h0000, 0, 0, 0, 1, 3'd1);
      pulse_lights();
      chk_outs("t1_timing", 16'h0000, 0, 0, 0, 1, 3'd2);
      ticks(237);
      chk_outs("t1_count", 16'h0237, 0, 0, 0, 1, 3'd2);
      press();
      chk_outs("t1_done", 16'h0237, 1, 0, 0, 0, 3'd3);
      ticks(5);
      pulse_lights();
      chk_outs("t1_hold", 16'h0237, 1, 0, 0, 0, 3'd3);

      // 2: jump start, later lights_out and ticks do nothing
      pulse_seq();
      chk_outs("t2_armed", 16'h0000, 0, 0, 0, 1, 3'd1);
      press();
      chk_outs("t2_jump", 16'h0000, 0, 1, 0, 0, 3'd4);
      pulse_lights();
      ticks(20);
      chk_outs("t2_hold", 16'h0000, 0, 1, 0, 0, 3'd4);

      // 3: no response, saturation at 9999
      pulse_seq();
      pulse_lights();
      ticks(9999);
      chk_outs("t3_9999", 16'h9999, 0, 0, 0, 1, 3'd2);
      ticks(1);
      chk_outs("t3_nores", 16'h9999, 0, 0, 1, 0, 3'd5);
      ticks(5);
      press();
      chk_outs("t3_hold", 16'h9999, 0, 0, 1, 0, 3'd5);

      // 4: button held from seq_start gives exactly one press
      bus.button    = 1'b1;
      bus.seq_start = 1'b1;
      cyc();
      bus.seq_start = 1'b0;
      cyc();
      cyc();
      pulse_lights();
      chk_outs("t4_jump", 16'h0000, 0, 1, 0, 0, 3'd4);
      repeat (50) cyc();
      chk_outs("t4_held", 16'h0000, 0, 1, 0, 0, 3'd4);
      pulse_seq();
      repeat (50) cyc();
      chk_outs("t4_rearm", 16'h0000, 0, 0, 0, 1, 3'd1);
      bus.button = 1'b0;
      repeat (3) cyc();

      // ARMED with press and lights_out in the same cycle
      pulse_seq();
      bus.button = 1'b1;
      cyc();
      cyc();
      bus.lights_out = 1'b1;
      cyc();
      bus.lights_out = 1'b0;
      chk_outs("same_cyc", 16'h0000, 1, 0, 0, 0, 3'd3);
      bus.button = 1'b0;
      repeat (3) cyc();

      // 5: press and tick collide at 0099; then tick alone 0099 -> 0100
      pulse_seq();
      pulse_lights();
      ticks(99);
      chk_outs("t5_0099", 16'h0099, 0, 0, 0, 1, 3'd2);
      bus.button = 1'b1;
      cyc();
      cyc();
      bus.tick_ms = 1'b1;
      cyc();
      bus.tick_ms = 1'b0;
      chk_outs("t5_collide", 16'h0099, 1, 0, 0, 0, 3'd3);
      bus.button = 1'b0;
      repeat (3) cyc();
      pulse_seq();
      pulse_lights();
      ticks(99);
      ticks(1);
      chk_outs("t5_0100", 16'h0100, 0, 0, 0, 1, 3'd2);
      ticks(900);
      chk_outs("t5_1000", 16'h1000, 0, 0, 0, 1, 3'd2);

      // 6: asynchronous reset mid-TIMING, then seq_start after DONE
      pulse_seq();
      pulse_lights();
      ticks(42);
      chk_outs("t6_0042", 16'h0042, 0, 0, 0, 1, 3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("t6_async", 16'h0000, 0, 0, 0, 0, 3'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      pulse_seq();
      pulse_lights();
      ticks(7);
      press();
      chk_outs("t6_done", 16'h0007, 1, 0, 0, 0, 3'd3);
      pulse_seq();
      chk_outs("t6_rearm", 16'h0000, 0, 0, 0, 1, 3'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
